instruction_encoder: RTL and testbench



---
 rtl/instruction_encoder_if.sv | 37 +++
 rtl/instruction_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_instruction_encoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/instruction_encoder_if.sv
// Field-set input / instruction-word output bundle for instruction_encoder.
// The master side drives field sets and takes encoded words; the slave side is the encoder.
interface instruction_encoder_if #(
    parameter int ID_WIDTH       = 7,
    parameter int REGISTER_WIDTH = 4,
    parameter int OFFSET_WIDTH   = 12,
    parameter int ADDRESS_WIDTH  = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ID_WIDTH-1:0]       ID;
    logic [REGISTER_WIDTH-1:0] RegD;
    logic [REGISTER_WIDTH-1:0] RegA;
    logic [REGISTER_WIDTH-1:0] RegB;
    logic [OFFSET_WIDTH-1:0]   Offset;
    logic [REGISTER_WIDTH:0]   branch_condition;
    logic [ADDRESS_WIDTH-1:0]  start_address;
    logic                      address_load;
    logic                      out_valid;
    logic                      out_ready;
    logic [15:0]               out_word;
    logic [ADDRESS_WIDTH-1:0]  out_address;
    logic                      error;
    logic [ID_WIDTH-1:0]       error_id;

    modport master (
        output in_valid, ID, RegD, RegA, RegB, Offset, branch_condition,
               start_address, address_load, out_ready,
        input  in_ready, out_valid, out_word, out_address, error, error_id
    );

    modport slave (
        input  in_valid, ID, RegD, RegA, RegB, Offset, branch_condition,
               start_address, address_load, out_ready,
        output in_ready, out_valid, out_word, out_address, error, error_id
    );
endinterface

// File: rtl/instruction_encoder.sv
// Re-encodes decoded micro-op fields into 16-bit ARMAria words with a sequential write address.
// Define ENCODER_FIELD_CHECK_EN to also reject field sets whose values overflow their encoded fields.
module instruction_encoder #(
    parameter int ID_WIDTH       = 7,
    parameter int REGISTER_WIDTH = 4,
    parameter int OFFSET_WIDTH   = 12,
    parameter int ADDRESS_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    instruction_encoder_if.slave  bus
);
    logic [ADDRESS_WIDTH-1:0] count, count_next;
    logic                     out_valid;
    logic [15:0]              out_word;
    logic [ADDRESS_WIDTH-1:0] out_address;
    logic                     error;
    logic [ID_WIDTH-1:0]      error_id;

    logic [31:0] idv;
    logic [3:0]  sub;
    logic [2:0]  rd, ra, rb, x;
    logic [7:0]  off;
    logic [15:0] word;
    logic        known, bad_field, ok;
    logic        use_rd, use_ra, use_rb, use_bc;
    logic [3:0]  off_w;
    logic        accept, out_xfer;

    assign idv = 32'(bus.ID);
    assign rd  = bus.RegD[2:0];
    assign ra  = bus.RegA[2:0];
    assign rb  = bus.RegB[2:0];
    assign off = bus.Offset[7:0];

    always_comb begin
        word   = '0;
        known  = 1'b1;
        use_rd = 1'b0;
        use_ra = 1'b0;
        use_rb = 1'b0;
        use_bc = 1'b0;
        off_w  = 4'd0;
        sub    = '0;
        x      = '0;
        case (idv) inside
            32'd1, 32'd2: begin
                word = {4'h0, idv == 32'd2, off[4:0], ra, rd};
                use_ra = 1'b1; use_rd = 1'b1; off_w = 4'd5;
            end
            32'd3: begin
                word = {4'h1, 1'b0, off[4:0], ra, rd};
                use_ra = 1'b1; use_rd = 1'b1; off_w = 4'd5;
            end
            [32'd4:32'd7]: begin
                // IDs 4/5 take a register operand, 6/7 a 3-bit immediate in the same slot
                sub = 4'(idv - 32'd4);
                x   = (idv < 32'd6) ? rb : off[2:0];
                word = {4'h1, 1'b1, sub[1:0], x, ra, rd};
                use_rb = (idv < 32'd6); use_ra = 1'b1; use_rd = 1'b1;
                off_w  = (idv < 32'd6) ? 4'd0 : 4'd3;
            end
            [32'd8:32'd11]: begin
                sub = 4'(idv - 32'd8);
                word = {4'h2 + {3'b0, sub[1]}, idv[0], rd, off};
                use_rd = 1'b1; off_w = 4'd8;
            end
            [32'd12:32'd27]: begin
                sub = 4'(idv - 32'd12);
                word = {4'h4, 2'b00, sub, rb, rd};
                use_rb = 1'b1; use_rd = 1'b1;
            end
            [32'd28:32'd30]: begin
                sub = 4'(idv - 32'd27);
                word = {8'h44, sub[1:0], rb, rd};
                use_rb = 1'b1; use_rd = 1'b1;
            end
            [32'd31:32'd33]: begin
                sub = 4'(idv - 32'd30);
                word = {8'h45, sub[1:0], rb, rd};
                use_rb = 1'b1; use_rd = 1'b1;
            end
            [32'd34:32'd37]: begin
                sub = 4'(idv - 32'd34);
                word = {8'h46, sub[1:0], rb, rd};
                use_rb = 1'b1; use_rd = 1'b1;
            end
            32'd38: begin
                word = {8'h47, bus.branch_condition[3:0], 1'b0, rb};
                use_rb = 1'b1; use_bc = 1'b1;
            end
            32'd76: begin
                word = {8'h47, 4'hF, 1'b0, rb};
                use_rb = 1'b1;
            end
            32'd39: begin
                word = {4'h4, 1'b1, rd, off};
                use_rd = 1'b1; off_w = 4'd8;
            end
            [32'd40:32'd47]: begin
                sub = 4'(idv - 32'd40);
                word = {4'h5, sub[2:0], rb, ra, rd};
                use_rb = 1'b1; use_ra = 1'b1; use_rd = 1'b1;
            end
            [32'd48:32'd53]: begin
                sub = 4'(idv - 32'd48);
                word = {4'h6 + {2'b0, sub[2:1]}, idv[0], off[4:0], ra, rd};
                use_ra = 1'b1; use_rd = 1'b1; off_w = 4'd5;
            end
            [32'd54:32'd57]: begin
                sub = 4'(idv - 32'd54);
                word = {4'h9 + {3'b0, sub[1]}, idv[0], rd, off};
                use_rd = 1'b1; off_w = 4'd8;
            end
            32'd58: word = 16'hB000;
            [32'd59:32'd62]: begin
                sub = 4'(idv - 32'd59);
                word = {8'hB2, sub[1:0], rb, rd};
                use_rb = 1'b1; use_rd = 1'b1;
            end
            [32'd63:32'd66]: begin
                sub = 4'(idv - 32'd63);
                word = {8'hBA, sub[1:0], rb, rd};
                use_rb = 1'b1; use_rd = 1'b1;
            end
            32'd67: begin word = 16'hB400 | {13'b0, rd}; use_rd = 1'b1; end
            32'd68: begin word = 16'hBD00 | {13'b0, rd}; use_rd = 1'b1; end
            32'd69: begin word = 16'hBE00 | {13'b0, rd}; use_rd = 1'b1; end
            32'd70: word = 16'hBE40;
            32'd71: begin word = 16'hBE80 | {13'b0, rd}; use_rd = 1'b1; end
            32'd72: word = 16'hC000;
            32'd73: begin
                word = {4'hD, bus.branch_condition[3:0], off};
                use_bc = 1'b1; off_w = 4'd8;
            end
            32'd74: word = 16'hE000;
            32'd75, 32'd77: word = 16'hE800;
            32'd100: word = 16'hFFFF;
            default: known = 1'b0;
        endcase
    end

`ifdef ENCODER_FIELD_CHECK_EN
    assign bad_field = (use_rd && ((bus.RegD >> 3) != '0))
                    || (use_ra && ((bus.RegA >> 3) != '0))
                    || (use_rb && ((bus.RegB >> 3) != '0))
                    || ((off_w != 4'd0) && ((bus.Offset >> off_w) != '0))
                    || (use_bc && bus.branch_condition[REGISTER_WIDTH]);
`else
    logic unused_fields;
    assign unused_fields = ^{use_rd, use_ra, use_rb, use_bc, off_w,
                             bus.RegD, bus.RegA, bus.RegB, bus.Offset, bus.branch_condition};
    assign bad_field = 1'b0;
`endif

    assign ok       = known && !bad_field;
    assign accept   = bus.in_valid && bus.in_ready;
    assign out_xfer = out_valid && bus.out_ready;

    // A word's address is the counter value it will hold while it waits in the output register.
    always_comb begin
        count_next = count;
        if (bus.address_load)
            count_next = bus.start_address;
        else if (out_xfer)
            count_next = count + ADDRESS_WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            out_valid   <= 1'b0;
            out_word    <= '0;
            out_address <= '0;
            error       <= 1'b0;
            error_id    <= '0;
        end else begin
            count <= count_next;
            if (accept && ok) begin
                out_valid   <= 1'b1;
                out_word    <= word;
                out_address <= count_next;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
            if (accept && !ok) begin
                error <= 1'b1;
                if (!error)
                    error_id <= bus.ID;
            end
        end
    end

    assign bus.in_ready    = !out_valid || bus.out_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_word    = out_word;
    assign bus.out_address = out_address;
    assign bus.error       = error;
    assign bus.error_id    = error_id;
endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: handshake, stall, errors, address wrap, reset, encodings.
module tb_instruction_encoder;
    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    instruction_encoder_if #(.ID_WIDTH(7), .REGISTER_WIDTH(4), .OFFSET_WIDTH(12), .ADDRESS_WIDTH(16)) bus ();

    instruction_encoder #(.ID_WIDTH(7), .REGISTER_WIDTH(4), .OFFSET_WIDTH(12), .ADDRESS_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one field set and returns just after the edge that accepted it.
    task automatic send(input logic [6:0] id, input logic [3:0] rd, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [11:0] off, input logic [4:0] bc);
        bus.ID = id; bus.RegD = rd; bus.RegA = ra; bus.RegB = rb;
        bus.Offset = off; bus.branch_condition = bc;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) begin
                step();
                bus.in_valid = 1'b0;
                return;
            end
            step();
        end
        bus.in_valid = 1'b0;
        total++;
        bad++;
        $error("FAIL send_timeout id=%0d in_ready=%b required=1", id, bus.in_ready);
    endtask

    logic [6:0]  t_id  [12] = '{7'd5, 7'd6, 7'd20, 7'd29, 7'd45, 7'd51, 7'd57, 7'd64, 7'd71, 7'd76, 7'd100, 7'd39};
    logic [3:0]  t_rd  [12] = '{4'd1, 4'd7, 4'd1, 4'd3, 4'd3, 4'd0, 4'd4, 4'd0, 4'd5, 4'd0, 4'd0, 4'd2};
    logic [3:0]  t_ra  [12] = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0]  t_rb  [12] = '{4'd3, 4'd0, 4'd6, 4'd2, 4'd1, 4'd0, 4'd0, 4'd7, 4'd0, 4'd3, 4'd0, 4'd0};
    logic [11:0] t_off [12] = '{12'h0, 12'h5, 12'h0, 12'h0, 12'h0, 12'h1F, 12'hC3, 12'h0, 12'h0, 12'h0, 12'h0, 12'h81};
    logic [15:0] t_exp [12] = '{16'h1AD1, 16'h1D47, 16'h4231, 16'h4493, 16'h5A53, 16'h7FC0,
                                16'hACC3, 16'hBA78, 16'hBE85, 16'h47F3, 16'hFFFF, 16'h4A81};

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.address_load = 1'b0; bus.start_address = '0;
        bus.ID = '0; bus.RegD = '0; bus.RegA = '0; bus.RegB = '0; bus.Offset = '0; bus.branch_condition = '0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_word", 32'(bus.out_word), 32'h0);
        chk("rst_out_address", 32'(bus.out_address), 32'h0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_error_id", 32'(bus.error_id), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        bus.address_load = 1'b1; bus.start_address = 16'h0100;
        step();
        bus.address_load = 1'b0;
        send(7'd8, 4'd3, 4'd0, 4'd0, 12'h05A, 5'd0);
        chk("id8_valid", 32'(bus.out_valid), 32'd1);
        chk("id8_word", 32'(bus.out_word), 32'h235A);
        chk("id8_addr", 32'(bus.out_address), 32'h0100);

        send(7'd73, 4'd0, 4'd0, 4'd0, 12'h010, 5'hE);
        chk("id73_word", 32'(bus.out_word), 32'hDE10);
        chk("id73_addr", 32'(bus.out_address), 32'h0101);
        send(7'd38, 4'd0, 4'd0, 4'd5, 12'h000, 5'hE);
        chk("id38_word", 32'(bus.out_word), 32'h47E5);
        chk("id38_addr", 32'(bus.out_address), 32'h0102);

        // Stall: word held, input blocked, then a combined transfer+accept.
        bus.out_ready = 1'b0;
        bus.ID = 7'd72; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_word", 32'(bus.out_word), 32'h47E5);
            chk("stall_addr", 32'(bus.out_address), 32'h0102);
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("resume_valid", 32'(bus.out_valid), 32'd1);
        chk("resume_word", 32'(bus.out_word), 32'hC000);
        chk("resume_addr", 32'(bus.out_address), 32'h0103);

        send(7'h7E, 4'd0, 4'd0, 4'd0, 12'h0, 5'd0);
        chk("bad7e_valid", 32'(bus.out_valid), 32'd0);
        chk("bad7e_error", 32'(bus.error), 32'd1);
        chk("bad7e_error_id", 32'(bus.error_id), 32'h7E);
        send(7'h7D, 4'd0, 4'd0, 4'd0, 12'h0, 5'd0);
        chk("bad7d_valid", 32'(bus.out_valid), 32'd0);
        chk("bad7d_error_id", 32'(bus.error_id), 32'h7E);
        send(7'd58, 4'd0, 4'd0, 4'd0, 12'h0, 5'd0);
        chk("id58_valid", 32'(bus.out_valid), 32'd1);
        chk("id58_word", 32'(bus.out_word), 32'hB000);
        chk("id58_addr", 32'(bus.out_address), 32'h0104);

        // Load coincides with the B000 transfer; the load must win.
        bus.address_load = 1'b1; bus.start_address = 16'hFFFF;
        step();
        bus.address_load = 1'b0;
        send(7'd74, 4'd0, 4'd0, 4'd0, 12'h0, 5'd0);
        chk("wrap0_word", 32'(bus.out_word), 32'hE000);
        chk("wrap0_addr", 32'(bus.out_address), 32'hFFFF);
        send(7'd74, 4'd0, 4'd0, 4'd0, 12'h0, 5'd0);
        chk("wrap1_addr", 32'(bus.out_address), 32'h0000);

        for (int i = 0; i < 12; i++) begin
            send(t_id[i], t_rd[i], t_ra[i], t_rb[i], t_off[i], 5'd0);
            chk($sformatf("enc_id%0d", t_id[i]), 32'(bus.out_word), 32'(t_exp[i]));
        end

        // Reset with a stalled word pending.
        bus.out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_addr", 32'(bus.out_address), 32'h0);
        chk("midrst_error", 32'(bus.error), 32'd0);
        bus.out_ready = 1'b1;

        send(7'd1, 4'd2, 4'd5, 4'd0, 12'h020, 5'd0);
`ifdef ENCODER_FIELD_CHECK_EN
        chk("id1_ovf_valid", 32'(bus.out_valid), 32'd0);
        chk("id1_ovf_error", 32'(bus.error), 32'd1);
        chk("id1_ovf_error_id", 32'(bus.error_id), 32'd1);
`else
        chk("id1_trunc_valid", 32'(bus.out_valid), 32'd1);
        chk("id1_trunc_word", 32'(bus.out_word), 32'h002A);
        chk("id1_trunc_addr", 32'(bus.out_address), 32'h0000);
        chk("id1_trunc_error", 32'(bus.error), 32'd0);
`endif
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
